// File: rtl/srl16_chain_top.sv
// srl16_chain_top: self-checking SRL16 shift-register chain test.
// An LFSR feeds 8 lanes of cascaded SRL16-style delay lines; each lane's output is
// compared against a reference LFSR started D_i cycles late. Mismatches latch
// sticky per-lane error bits on led[7:0]; led[8] shows all lanes primed and
// led[15:9] is a heartbeat.
// Optional feature: define SRL16_FAULT_INJECT_EN to XOR sw[i] into lane i's input.
module srl16_chain_top #(
  parameter int          NUM_LANES = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  // Longest lane delay; the warm-up counter saturates here.
  localparam int                 MAX_D   = 15 * (NUM_LANES - 1) + 16;
  localparam int                 CNT_W   = 7;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_D);

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  logic [15:0]          gen_q = LFSR_SEED;
  logic [15:0]          gen_d;
  logic [CNT_W-1:0]     cnt_q = '0;
  logic [CNT_W-1:0]     cnt_d;
  logic [15:0]          ref_q [NUM_LANES] = '{default: LFSR_SEED};
  logic [15:0]          ref_d [NUM_LANES];
  logic [NUM_LANES-1:0] err_q = '0;
  logic [NUM_LANES-1:0] err_d;
  logic [26:0]          hb_q = '0;
  logic [26:0]          hb_d;

  logic [NUM_LANES-1:0] lane_in;
  logic [NUM_LANES-1:0] chain_out;
  logic [NUM_LANES-1:0] primed;
  logic [NUM_LANES-1:0] ref_bit;
  logic                 unused_in;

  // UART receive and the spare switches have no function in this test.
  assign unused_in = ^{rx, sw};

`ifdef SRL16_FAULT_INJECT_EN
  assign lane_in = {NUM_LANES{gen_q[0]}} ^ sw[NUM_LANES-1:0];
`else
  assign lane_in = {NUM_LANES{gen_q[0]}};
`endif

  // Per-lane cascade of SRL16 models; contents are never reset, so priming must
  // wait a full lane delay before any output is trusted.
  for (genvar L = 0; L < NUM_LANES; L++) begin : g_lane
    localparam int D = 15 * L + 16;

    logic [15:0] sr_q [L+1] = '{default: '0};
    logic [L+1:0] tap;
    logic         unused_msb;

    assign tap[0]     = lane_in[L];
    // Bit 15 of the last stage is unread when its address is below 15.
    assign unused_msb = sr_q[L][15];

    for (genvar k = 0; k <= L; k++) begin : g_stage
      localparam int A = (k == L) ? (15 - L) : 15;
      assign tap[k+1] = sr_q[k][A];
    end

    // Shift every stage each cycle (clock enable permanently high).
    always_ff @(posedge clk) begin
      for (int k = 0; k <= L; k++) begin
        sr_q[k] <= {sr_q[k][14:0], tap[k]};
      end
    end

    assign chain_out[L] = tap[L+1];
    assign primed[L]    = (cnt_q >= CNT_W'(D));
    assign ref_bit[L]   = ref_q[L][0];
  end

  // Next-state for generator, warm-up counter, checkers, errors and heartbeat.
  always_comb begin
    gen_d = lfsr_next(gen_q);
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    for (int l = 0; l < NUM_LANES; l++) begin
      ref_d[l] = primed[l] ? lfsr_next(ref_q[l]) : ref_q[l];
    end
    err_d = err_q | (primed & (chain_out ^ ref_bit));
    hb_d  = hb_q + 27'd1;
  end

  // Generator LFSR and warm-up counter; reset un-primes every checker at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_q <= LFSR_SEED;
      cnt_q <= '0;
    end else begin
      gen_q <= gen_d;
      cnt_q <= cnt_d;
    end
  end

  // Reference LFSRs and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        ref_q[l] <= LFSR_SEED;
      end
      err_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        ref_q[l] <= ref_d[l];
      end
      err_q <= err_d;
    end
  end

  // Free-running heartbeat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_q <= '0;
    end else begin
      hb_q <= hb_d;
    end
  end

  assign tx  = 1'b1;
  assign led = {hb_q[26:20], &primed, err_q};

endmodule

// File: tb/tb_srl16_chain_top.sv
// Testbench for srl16_chain_top: phase table plus hand-written corner sequences,
// with a cycle-level reference model built from lane delays and LFSR history.
module tb_srl16_chain_top;

  localparam logic [15:0] SEED = 16'hACE1;
`ifdef SRL16_FAULT_INJECT_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        tx;
  logic [15:0] sw  = 16'h0000;
  logic [15:0] led;

  srl16_chain_top #(.NUM_LANES(8), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .sw(sw), .led(led)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: cycle index since reset, generator bit history and
  // switch history (ring buffers longer than the longest lane delay).
  int          t = 0;
  logic [15:0] mlfsr = SEED;
  logic        gh  [256];
  logic [15:0] swh [256];
  logic [7:0]  exp_err = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %h expected %h", nm, t, act, exp);
    end
  endtask

  function automatic logic [15:0] poly_step(input logic [15:0] s);
    // Feedback from taps 16,14,13,11 of the polynomial (bits 0,2,3,5 here).
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [16:0] exp_out();
    logic [6:0] hb;
    hb = 7'((t >> 20) & 127);
    return {1'b1, hb, (t >= 121), exp_err};
  endfunction

  // One clock: model advances from cycle t to t+1, outputs are checked, and new
  // inputs are applied for the new cycle.
  task automatic step(input logic [15:0] nsw);
    int   d, s;
    logic chain_b, ref_b;
    @(posedge clk);
    @(negedge clk);
    for (int L = 0; L < 8; L++) begin
      d = 15 * L + 16;
      if (t >= d) begin
        s       = (t - d) % 256;
        ref_b   = gh[s];
        chain_b = gh[s] ^ (FAULT & swh[s][L]);
        if (chain_b != ref_b) exp_err[L] = 1'b1;
      end
    end
    t++;
    mlfsr        = poly_step(mlfsr);
    gh[t % 256]  = mlfsr[0];
    chk("led_tx", {15'd0, tx, led}, {15'd0, exp_out()});
    sw           = nsw;
    rx           = 1'($urandom_range(0, 1));
    swh[t % 256] = nsw;
  endtask

  task automatic model_restart();
    t        = 0;
    mlfsr    = SEED;
    gh[0]    = mlfsr[0];
    swh[0]   = sw;
    exp_err  = 8'h00;
  endtask

  // Asynchronous reset pulse applied mid-cycle, held for three edges.
  task automatic do_reset(input logic [15:0] hold_sw);
    sw  = hold_sw;
    rst = 1'b1;
    #1;
    chk("async_clear", {15'd0, tx, led}, {15'd0, 1'b1, 16'h0000});
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("in_reset", {15'd0, tx, led}, {15'd0, 1'b1, 16'h0000});
    end
    rst = 1'b0;
    model_restart();
  endtask

  typedef struct {
    string       name;
    bit          do_rst;
    int          cycles;
    logic [15:0] sw;
    logic [7:0]  exp_fault;
    logic [7:0]  exp_nofault;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int   lat;
    bit   found;
    logic [15:0] rsw;

    model_restart();

    vecs[0] = '{"powerup_no_rst", 1'b0, 200,   16'h0000, 8'h00, 8'h00};
    vecs[1] = '{"rst_clean",      1'b1, 300,   16'h0000, 8'h00, 8'h00};
    vecs[2] = '{"sw_all_ones",    1'b0, 10000, 16'hFFFF, 8'hFF, 8'h00};
    vecs[3] = '{"rst_clears",     1'b1, 200,   16'h0000, 8'h00, 8'h00};
    vecs[4] = '{"rst_run",        1'b1, 200,   16'h0000, 8'h00, 8'h00};

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].do_rst) do_reset(vecs[v].sw);
      for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].sw);
      chk(vecs[v].name, {24'd0, led[7:0]},
          {24'd0, (FAULT ? vecs[v].exp_fault : vecs[v].exp_nofault)});
      chk({vecs[v].name, "_primed"}, {31'd0, led[8]}, 32'd1);
    end

    // Fault on lane 3 after priming: detection within 63 cycles, others clean.
    found = 1'b0;
    lat   = 0;
    step(16'h0008);
    for (int c = 1; c <= 63 && !found; c++) begin
      step(16'h0008);
      if (led[3]) begin
        found = 1'b1;
        lat   = c;
      end
    end
    chk("sw3_detect", {31'd0, found}, {31'd0, FAULT});
    if (found) chk("sw3_latency_le_63", {31'd0, (lat <= 63)}, 32'd1);
    chk("sw3_other_lanes", {24'd0, led[7:0] & 8'hF7}, 32'd0);

    // Clearing the switch leaves the flag latched.
    repeat (100) step(16'h0000);
    chk("sw3_sticky", {31'd0, led[3]}, {31'd0, FAULT});

    // Reset clears flags; all-primed re-rises exactly 121 cycles later.
    do_reset(16'h0000);
    repeat (120) step(16'h0000);
    chk("led8_before_121", {31'd0, led[8]}, 32'd0);
    step(16'h0000);
    chk("led8_at_121", {31'd0, led[8]}, 32'd1);
    chk("no_err_after_rst", {24'd0, led[7:0]}, 32'd0);

    // Randomized switch activity against the model.
    do_reset(16'h0000);
    rsw = 16'h0000;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 63) == 0) rsw[$urandom_range(0, 15)] ^= 1'b1;
      step(rsw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
